// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit and instruction memory.
// The fetch unit drives the master side; memory (or a testbench) drives the slave side.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Multicycle MIPS instruction-fetch stage: owns the PC, fetches one word at a time
// into the instruction register and resolves next-PC from branch/jump/zero.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_fetch_unit_if.master imem,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam int unsigned CW = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 32'd1);
  // Low address bits forced to zero so the PC stays word-aligned whatever RESET_PC is.
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] btarget_s;
  logic [31:0] jtarget_s;
  logic [31:0] next_pc_s;
  logic        taken_s;

  // Next-PC resolution; ir[26] distinguishes bne (1) from beq (0).
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    taken_s    = branch & (alu_zero ^ ir_q[26]);
    btarget_s  = pc_plus4_s + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    jtarget_s  = {pc_plus4_s[31:28], ir_q[25:0], 2'b00};
    if (jump) begin
      next_pc_s = jtarget_s;
    end else if (taken_s) begin
      next_pc_s = btarget_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch FSM next-state and register updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
      S_FETCH: begin
        // A response on the last permitted cycle beats the timeout.
        if (imem.imem_ready) begin
          ir_d       = imem.imem_rdata;
          wait_cnt_d = '0;
          state_d    = S_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if ((TIMEOUT_CYC != 32'd0) && (wait_cnt_q == CNT_LAST)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        if (exec_done && !stall) begin
          pc_d    = next_pc_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_INIT;
      ir_q       <= 32'h0000_0000;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = ir_q;
  assign op             = ir_q[31:26];
  assign funct          = ir_q[5:0];
  assign instr_valid    = (state_q == S_EXEC);
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_s;
  assign fetch_err      = (state_q == S_ERR);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit: expected fetch addresses are queued when
// an instruction is retired and compared when the DUT raises its next request.
module tb_mips_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int unsigned TO     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  op, funct;
  logic        instr_valid, fetch_err;
  logic        exec_done, branch, jump, alu_zero, stall;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mips_fetch_unit_if imem_bus();

  mips_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus.master),
    .instr      (instr),
    .op         (op),
    .funct      (funct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exec_done  (exec_done),
    .branch     (branch),
    .jump       (jump),
    .alu_zero   (alu_zero),
    .stall      (stall),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then compare its address with the scoreboard head.
  task automatic wait_req(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
    check({tag, "_addr"}, imem_bus.imem_addr, e);
    check({tag, "_pc"}, pc, e);
  endtask

  task automatic respond(input string tag, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = d;
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, d);
    check({tag, "_op"}, {26'd0, op}, {26'd0, d[31:26]});
    check({tag, "_funct"}, {26'd0, funct}, {26'd0, d[5:0]});
    check({tag, "_noreq"}, {31'd0, imem_bus.imem_req}, 32'd0);
  endtask

  task automatic do_exec(input string tag, input logic b, input logic j, input logic z,
                         input logic [31:0] nxt);
    exp_q.push_back(nxt);
    exec_done = 1'b1; branch = b; jump = j; alu_zero = z;
    @(negedge clk);
    exec_done = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
    check({tag, "_exec_exit"}, {31'd0, instr_valid}, 32'd0);
    wait_req(tag);
  endtask

  initial begin
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    exec_done = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_addr", imem_bus.imem_addr, RST_PC);
    check("rst_op", {26'd0, op}, 32'd0);
    check("rst_funct", {26'd0, funct}, 32'd0);

    // Boot: request must be up one cycle after release.
    exp_q.push_back(RST_PC);
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_req_cycle1", {31'd0, imem_bus.imem_req}, 32'd1);
    wait_req("boot");
    respond("boot", 32'h2008_0005);
    check("boot_op08", {26'd0, op}, 32'h08);
    check("boot_funct05", {26'd0, funct}, 32'h05);
    check("boot_pc4", pc_plus4, 32'h0040_0004);
    do_exec("seq", 1'b0, 1'b0, 1'b0, 32'h0040_0004);

    // Branch and jump resolution.
    respond("j1", 32'h0810_0004);     do_exec("j1", 1'b0, 1'b1, 1'b0, 32'h0040_0010);
    respond("beq", 32'h1000_FFFF);    do_exec("beq", 1'b1, 1'b0, 1'b1, 32'h0040_0010);
    respond("bne_z1", 32'h1400_FFFF); do_exec("bne_z1", 1'b1, 1'b0, 1'b1, 32'h0040_0014);
    respond("j2", 32'h0810_0004);     do_exec("j2", 1'b0, 1'b1, 1'b0, 32'h0040_0010);
    respond("bne_z0", 32'h1400_FFFF); do_exec("bne_z0", 1'b1, 1'b0, 1'b0, 32'h0040_0010);
    respond("j3", 32'h0810_0008);     do_exec("j3", 1'b0, 1'b1, 1'b0, 32'h0040_0020);
    respond("jmp", 32'h0810_0003);    do_exec("jmp", 1'b0, 1'b1, 1'b0, 32'h0040_000C);
    respond("j4", 32'h0810_0008);     do_exec("j4", 1'b0, 1'b1, 1'b0, 32'h0040_0020);
    respond("jmp_br", 32'h0810_0003); do_exec("jmp_br", 1'b1, 1'b1, 1'b1, 32'h0040_000C);

    // Stall beats exec_done in EXEC.
    respond("stall", 32'h0000_0020);
    stall = 1'b1; exec_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h0040_000C);
      check("stall_instr", instr, 32'h0000_0020);
      check("stall_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    exp_q.push_back(32'h0040_0010);
    @(negedge clk);
    exec_done = 1'b0;
    wait_req("stall_adv");

    // Ready on the final (8th) permitted request cycle.
    repeat (TO - 1) begin
      @(negedge clk);
      check("late_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("late_noerr", {31'd0, fetch_err}, 32'd0);
    end
    respond("late", 32'h012A_4020);
    check("late_err", {31'd0, fetch_err}, 32'd0);
    do_exec("late", 1'b0, 1'b0, 1'b0, 32'h0040_0014);

    // Timeout: no response at all.
    repeat (TO - 1) begin
      @(negedge clk);
      check("to_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("to_noerr", {31'd0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
    check("to_novalid", {31'd0, instr_valid}, 32'd0);
    imem_bus.imem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("err_sticky", {31'd0, fetch_err}, 32'd1);
      check("err_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    imem_bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err_rst_clr", {31'd0, fetch_err}, 32'd0);
    check("err_rst_pc", pc, RST_PC);
    @(negedge clk);
    exp_q.push_back(RST_PC);
    rst_n = 1'b1;
    @(negedge clk);
    wait_req("after_err");
    respond("after_err", 32'h2008_0005);
    do_exec("after_err", 1'b0, 1'b0, 1'b0, 32'h0040_0004);

    // Reset mid-FETCH with a response arriving during reset.
    @(negedge clk);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, RST_PC);
    check("midrst_addr", imem_bus.imem_addr, RST_PC);
    check("midrst_noreq", {31'd0, imem_bus.imem_req}, 32'd0);
    check("midrst_novalid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    exp_q.push_back(RST_PC);
    rst_n = 1'b1;
    @(negedge clk);
    wait_req("post_rst");
    check("post_rst_ir", instr, 32'h0000_0000);
    check("post_rst_novalid", {31'd0, instr_valid}, 32'd0);
    respond("post_rst", 32'h2008_0005);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
